timer_counter_param: RTL and testbench
======================================

Name: timer_counter_param

Overview:
- Parametrised successor to the 8-bit timer counter: WIDTH-bit up/down counter with an internal clock-enable prescaler.
- Three counting modes: free-run, auto-reload, one-shot.
- Compare-match flag plus sticky overflow/underflow flags.
- Sits in the timer subsystem between the register interface (start value, control, flag clears) and the interrupt logic (flags).

Parameters:
WIDTH, 8, counter and start/compare value width (>=2)
PRE_W, 8, prescaler width; tick divide ratios 2^0 .. 2^(PRE_W-1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
cks  input  $clog2(PRE_W)  prescaler select; tick every 2^cks clk cycles
start_counter  input  WIDTH  load / reload value
cmp_value  input  WIDTH  compare value
up_down  input  1  1 = count up, 0 = count down
mode  input  2  00 free-run, 01 auto-reload, 10 one-shot, 11 treated as 00
load  input  1  synchronous load of start_counter, also re-arms one-shot
enable  input  1  counting enable
clr_overflow  input  1  clear overflow flag
clr_underflow  input  1  clear underflow flag
clr_compare  input  1  clear cmp_match flag
tcnt  output  WIDTH  current count (reg_TCNT)
overflow  output  1  sticky overflow flag
underflow  output  1  sticky underflow flag
cmp_match  output  1  sticky compare-match flag
halted  output  1  one-shot finished, counting frozen until load

Behaviour:
- Reset: tcnt, prescaler, overflow, underflow, cmp_match and halted are all 0, asynchronously. Registers are released on the first clk edge after rst_n rises.
- Prescaler:
  - free-running PRE_W-bit counter, increments every clk, wraps naturally, unaffected by load/enable.
  - tick = 1 when cks == 0; otherwise tick = 1 when the low cks bits of the prescaler are all ones.
  - tick is combinational from the prescaler register.
  - cks >= PRE_W behaves as cks = PRE_W-1.
- Priority per clk edge: load > step > hold.
- load = 1: tcnt <= start_counter; halted <= 0. No flag is set by a load, even if start_counter == cmp_value.
- step condition: enable & tick & ~halted & ~load. Otherwise tcnt holds.
- Step up:
  - tcnt != all-ones: tcnt+1.
  - tcnt == all-ones: overflow <= 1; next value is start_counter in mode 01, 0 in modes 00/10/11.
  - mode 10 also sets halted <= 1.
- Step down:
  - tcnt != 0: tcnt-1.
  - tcnt == 0: underflow <= 1; next value is start_counter in mode 01, all-ones otherwise.
  - mode 10 also sets halted <= 1.
- Compare: on a step, if the new tcnt value == cmp_value, cmp_match <= 1. A match can coincide with an overflow/underflow.
- Flags:
  - registered, asserted on the same clk edge that updates tcnt (visible one cycle after the tick cycle).
  - sticky until their own clear input is seen high at a clk edge.
  - simultaneous set and clear: set wins, flag stays 1.
- up_down, mode, cmp_value and start_counter are sampled at the stepping edge only; changing them mid-count takes effect on the next step.
- enable low freezes tcnt and flags. The prescaler keeps running, so tick phase is not realigned.
- Reset mid-count: everything returns to reset state immediately. No flag survives reset.

Test Plan:
- Reset then load 0, up, mode 00, cks=0, enable=1 → tcnt counts 0..255 one per clk. overflow is set on the edge where tcnt goes 255→0; no flag before that; underflow stays 0.
- enable=0 with cks=0, 300 clk cycles after load 0 → tcnt stays 0, overflow/underflow/cmp_match stay 0.
- Auto-reload down, start_counter=5, cks=2, enable=1 → tcnt changes every 4 clk: 5,4,3,2,1,0. Then underflow=1 and tcnt=5 again. clr_underflow pulse clears the flag; a set and clear on the same edge leaves it 1.
- One-shot up, start_counter=250 → overflow at 255→0, halted=1, tcnt frozen at 0 for 50 clk. A load pulse sets halted=0 and counting resumes from 250.
- Compare, cmp_value=0x10, load 0x0E, up → cmp_match=1 on the edge tcnt becomes 0x10, not on load. A load of 0x10 alone does not set cmp_match.
- Async reset mid-count (tcnt=0x80, overflow=1) → all outputs 0 without a clk edge. Counting resumes from 0 after rst_n release only when enable=1.

Source files
------------

// File: rtl/timer_counter_param.sv
// timer_counter_param: WIDTH-bit up/down timer with a free-running clock-enable
// prescaler, free-run / auto-reload / one-shot modes, a sticky compare-match
// flag and sticky overflow/underflow flags for the interrupt logic.
module timer_counter_param #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8,
  localparam int CKS_W = (PRE_W > 1) ? $clog2(PRE_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CKS_W-1:0] cks,
  input  logic [WIDTH-1:0] start_counter,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic             up_down,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             enable,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  input  logic             clr_compare,
  output logic [WIDTH-1:0] tcnt,
  output logic             overflow,
  output logic             underflow,
  output logic             cmp_match,
  output logic             halted
);

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_mask;
  logic             tick;
  int               sel;

  logic [WIDTH-1:0] nxt;
  logic             at_max;
  logic             at_zero;
  logic             wrap;
  logic             step;
  logic             auto_rld;
  logic             one_shot;

  // Tick when the low 'sel' prescaler bits are all ones; sel = 0 ticks every clk.
  always_comb begin
    sel = (int'(cks) >= PRE_W) ? (PRE_W - 1) : int'(cks);
    pre_mask = '0;
    for (int i = 0; i < PRE_W; i++) begin
      pre_mask[i] = (i < sel);
    end
    tick = ((pre & pre_mask) == pre_mask);
  end

  // Next count for a step; mode 11 falls through to free-run behaviour.
  always_comb begin
    auto_rld = (mode == 2'b01);
    one_shot = (mode == 2'b10);
    at_max   = (tcnt == '1);
    at_zero  = (tcnt == '0);
    step     = enable & tick & ~halted & ~load;
    wrap     = up_down ? at_max : at_zero;
    if (up_down) begin
      if (at_max) nxt = auto_rld ? start_counter : '0;
      else        nxt = tcnt + WIDTH'(1);
    end else begin
      if (at_zero) nxt = auto_rld ? start_counter : '1;
      else         nxt = tcnt - WIDTH'(1);
    end
  end

  // Prescaler runs every clk regardless of load/enable so tick phase never realigns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre <= '0;
    else        pre <= pre + PRE_W'(1);
  end

  // Counter and flags: load beats step beats hold; a flag set beats its own clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      cmp_match <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (clr_overflow)  overflow  <= 1'b0;
      if (clr_underflow) underflow <= 1'b0;
      if (clr_compare)   cmp_match <= 1'b0;
      if (load) begin
        tcnt   <= start_counter;
        halted <= 1'b0;
      end else if (step) begin
        tcnt <= nxt;
        if (up_down && at_max)   overflow  <= 1'b1;
        if (!up_down && at_zero) underflow <= 1'b1;
        if (wrap && one_shot)    halted    <= 1'b1;
        if (nxt == cmp_value)    cmp_match <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_counter_param.sv
// Directed bench for timer_counter_param (WIDTH=8, PRE_W=8): a vector table of
// single-cycle steps at cks=0 plus hand-written multi-cycle sequences.
module tb_timer_counter_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cks = 3'd0;
  logic [7:0] start_counter = 8'd0;
  logic [7:0] cmp_value = 8'd0;
  logic       up_down = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic       enable = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       clr_underflow = 1'b0;
  logic       clr_compare = 1'b0;
  logic [7:0] tcnt;
  logic       overflow, underflow, cmp_match, halted;

  int n_cmp = 0;
  int n_bad = 0;

  timer_counter_param #(.WIDTH(8), .PRE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cks(cks), .start_counter(start_counter),
    .cmp_value(cmp_value), .up_down(up_down), .mode(mode), .load(load),
    .enable(enable), .clr_overflow(clr_overflow), .clr_underflow(clr_underflow),
    .clr_compare(clr_compare), .tcnt(tcnt), .overflow(overflow),
    .underflow(underflow), .cmp_match(cmp_match), .halted(halted)
  );

  always #5 clk = ~clk;

  // Independent prescaler model: counts clk edges since reset release.
  logic [7:0] pre_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_m <= 8'd0;
    else        pre_m <= pre_m + 8'd1;
  end

  function automatic logic tick_m(input logic [2:0] c);
    logic [7:0] m;
    m = (8'd1 << c) - 8'd1;
    return (pre_m & m) == m;
  endfunction

  typedef struct packed {
    logic       ld;
    logic [7:0] start;
    logic       en;
    logic       up;
    logic [1:0] md;
    logic [7:0] cmp;
    logic       co, cu, cc;
    logic [7:0] e_t;
    logic       e_o, e_u, e_c, e_h;
  } vec_t;

  vec_t vec [23];

  task automatic chk(input string nm, input logic [7:0] et, input logic eo,
                     input logic eu, input logic ec, input logic eh);
    n_cmp++;
    if ({tcnt, overflow, underflow, cmp_match, halted} !== {et, eo, eu, ec, eh}) begin
      n_bad++;
      $display("FAIL %s: got tcnt=%h ovf=%b unf=%b cmp=%b halt=%b, want tcnt=%h ovf=%b unf=%b cmp=%b halt=%b",
               nm, tcnt, overflow, underflow, cmp_match, halted, et, eo, eu, ec, eh);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_clr(input logic v);
    clr_overflow = v; clr_underflow = v; clr_compare = v;
  endtask

  logic [7:0] exp_t;
  logic       exp_u;
  logic       done;

  initial begin
    //           ld  start  en  up  md     cmp    co cu cc  e_t    o  u  c  h
    vec[0]  = '{1'b1, 8'hFD, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 8'hFD, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 8'hFD, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 8'hFD, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 8'hFD, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 8'hFD, 1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 8'hFD, 1'b1, 1'b0, 2'b00, 8'h40, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 8'hFD, 1'b1, 1'b0, 2'b00, 8'h40, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 8'hFD, 1'b1, 1'b0, 2'b00, 8'h40, 1'b0, 1'b1, 1'b0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 8'h03, 1'b1, 1'b0, 2'b01, 8'h40, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[10] = '{1'b0, 8'h03, 1'b1, 1'b0, 2'b01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b0, 8'h03, 1'b1, 1'b0, 2'b01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[12] = '{1'b0, 8'h03, 1'b1, 1'b0, 2'b01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[13] = '{1'b0, 8'h03, 1'b1, 1'b0, 2'b01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[14] = '{1'b1, 8'h01, 1'b1, 1'b0, 2'b10, 8'h40, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[15] = '{1'b0, 8'h01, 1'b1, 1'b0, 2'b10, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[16] = '{1'b0, 8'h01, 1'b1, 1'b0, 2'b10, 8'h40, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[17] = '{1'b0, 8'h01, 1'b1, 1'b0, 2'b10, 8'h40, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[18] = '{1'b1, 8'hFE, 1'b1, 1'b1, 2'b11, 8'h40, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[19] = '{1'b0, 8'hFE, 1'b1, 1'b1, 2'b11, 8'h40, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[20] = '{1'b0, 8'hFE, 1'b1, 1'b1, 2'b11, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[21] = '{1'b1, 8'h10, 1'b1, 1'b1, 2'b01, 8'h10, 1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[22] = '{1'b0, 8'h20, 1'b1, 1'b1, 2'b01, 8'h10, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled for 300 cycles after load 0
    load = 1'b1; start_counter = 8'h00; enable = 1'b0; cmp_value = 8'h00;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      chk("disabled_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Vector table, cks = 0
    cks = 3'd0;
    for (int i = 0; i < 23; i++) begin
      load = vec[i].ld; start_counter = vec[i].start; enable = vec[i].en;
      up_down = vec[i].up; mode = vec[i].md; cmp_value = vec[i].cmp;
      clr_overflow = vec[i].co; clr_underflow = vec[i].cu; clr_compare = vec[i].cc;
      cyc();
      chk($sformatf("vec%0d", i), vec[i].e_t, vec[i].e_o, vec[i].e_u, vec[i].e_c, vec[i].e_h);
    end
    load = 1'b0; set_clr(1'b0);

    // Free-run up 0..255 then overflow
    load = 1'b1; start_counter = 8'h00; up_down = 1'b1; mode = 2'b00; cks = 3'd0;
    enable = 1'b1; cmp_value = 8'h00; set_clr(1'b1);
    cyc();
    load = 1'b0; set_clr(1'b0);
    chk("free_load", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 256; i++) begin
      cyc();
      chk("free_count", 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc();
    chk("free_wrap", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // Auto-reload down from 5 with cks = 2
    load = 1'b1; start_counter = 8'd5; up_down = 1'b0; mode = 2'b01; cks = 3'd2;
    cmp_value = 8'hAA; set_clr(1'b1);
    cyc();
    load = 1'b0; set_clr(1'b0);
    exp_t = 8'd5; exp_u = 1'b0;
    chk("ar_load", exp_t, 1'b0, exp_u, 1'b0, 1'b0);
    for (int k = 0; k < 40 && !exp_u; k++) begin
      if (tick_m(cks)) begin
        if (exp_t == 8'd0) begin exp_t = 8'd5; exp_u = 1'b1; end
        else exp_t = exp_t - 8'd1;
      end
      cyc();
      chk("ar_step", exp_t, 1'b0, exp_u, 1'b0, 1'b0);
    end
    n_cmp++;
    if (!exp_u) begin
      n_bad++;
      $display("FAIL ar_timeout: no underflow within 40 cycles, want underflow=1");
    end
    enable = 1'b0; clr_underflow = 1'b1;
    cyc();
    clr_underflow = 1'b0; enable = 1'b1;
    chk("ar_clear", exp_t, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_u = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (tick_m(cks)) begin
        if (exp_t == 8'd0) begin
          exp_t = 8'd5; exp_u = 1'b1; done = 1'b1; clr_underflow = 1'b1;
        end else exp_t = exp_t - 8'd1;
      end
      cyc();
      clr_underflow = 1'b0;
      chk("ar_set_vs_clear", exp_t, 1'b0, exp_u, 1'b0, 1'b0);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL ar_timeout2: no second underflow within 40 cycles, want underflow=1");
    end

    // One-shot up from 250
    load = 1'b1; start_counter = 8'd250; up_down = 1'b1; mode = 2'b10; cks = 3'd0;
    enable = 1'b1; set_clr(1'b1);
    cyc();
    load = 1'b0; set_clr(1'b0);
    chk("os_load", 8'd250, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("os_count", 8'(250 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc();
    chk("os_wrap", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("os_frozen", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    load = 1'b1;
    cyc();
    load = 1'b0;
    chk("os_rearm", 8'd250, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("os_resume", 8'd251, 1'b1, 1'b0, 1'b0, 1'b0);

    // Compare match on a step, never on a load
    load = 1'b1; start_counter = 8'h0E; mode = 2'b00; up_down = 1'b1;
    cmp_value = 8'h10; set_clr(1'b1);
    cyc();
    load = 1'b0; set_clr(1'b0);
    chk("cmp_load", 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("cmp_before", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("cmp_hit", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    load = 1'b1; start_counter = 8'h10; clr_compare = 1'b1;
    cyc();
    load = 1'b0; clr_compare = 1'b0; enable = 1'b0;
    chk("cmp_load_eq", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-count at tcnt=0x80 with overflow set
    enable = 1'b1; load = 1'b1; start_counter = 8'hFF;
    cyc();
    load = 1'b0;
    cyc();
    load = 1'b1; start_counter = 8'h7F;
    cyc();
    load = 1'b0;
    cyc();
    chk("pre_reset", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    cyc();
    chk("post_reset_cnt1", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("post_reset_cnt2", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
